// File: rtl/l2_cache_arb_sched_pkg.sv
// rtl/l2_cache_arb_sched_pkg.sv - shared L2 request/line types and scheduler constants
package l2_cache_arb_sched_pkg;

    localparam int L2_FILL_BURST_LIMIT = 8;
    localparam int CACHE_LINE_BITS     = 512;
    localparam int L2_ADDR_WIDTH       = 32;
    localparam int CORE_ID_WIDTH       = 4;

    typedef enum logic [1:0] {
        L2REQ_LOAD       = 2'd0,
        L2REQ_STORE      = 2'd1,
        L2REQ_FLUSH      = 2'd2,
        L2REQ_INVALIDATE = 2'd3
    } l2req_type_t;

    typedef logic [CACHE_LINE_BITS-1:0] cache_line_data_t;

    typedef struct packed {
        logic                     valid;
        logic [CORE_ID_WIDTH-1:0] core;
        l2req_type_t              packet_type;
        logic [L2_ADDR_WIDTH-1:0] address;
    } l2req_packet_t;

    typedef enum logic [1:0] {
        GRANT_IDLE = 2'd0,
        GRANT_FILL = 2'd1,
        GRANT_CORE = 2'd2
    } grant_kind_t;

endpackage

// File: rtl/l2_cache_arb_sched_rr_arbiter.sv
// rtl/l2_cache_arb_sched_rr_arbiter.sv - round-robin arbiter, pointer advances only on update
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] i_request,
    input  logic                      i_update_lru,
    output logic [NUM_REQUESTERS-1:0] o_grant
);

    localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_grant_idx;

    // Scan upward starting just past the last winner, wrapping around.
    always_comb begin
        int         idx;
        logic [PTR_W-1:0] idx_b;
        logic       found;
        o_grant     = '0;
        w_grant_idx = r_ptr;
        found       = 1'b0;
        idx         = 0;
        idx_b       = '0;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            idx   = (int'(r_ptr) + i) % NUM_REQUESTERS;
            idx_b = PTR_W'(idx);
            if (!found && i_request[idx_b]) begin
                found          = 1'b1;
                o_grant[idx_b] = 1'b1;
                w_grant_idx    = idx_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= PTR_W'(NUM_REQUESTERS - 1);
        end else if (i_update_lru && (|i_request)) begin
            r_ptr <= w_grant_idx;
        end
    end

endmodule

// File: rtl/l2_cache_arb_sched.sv
// rtl/l2_cache_arb_sched.sv - L2 front scheduler: fill priority, core round-robin, fill burst limiter
module l2_cache_arb_sched
    import l2_cache_arb_sched_pkg::*;
#(
    parameter int NUM_CORES        = 4,
    parameter int FILL_BURST_LIMIT = L2_FILL_BURST_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] l2i_request_valid,
    input  l2req_packet_t        l2i_request [NUM_CORES],
    output logic [NUM_CORES-1:0] l2_ready,
    input  logic                 l2bi_fill_valid,
    input  l2req_packet_t        l2bi_request,
    input  cache_line_data_t     l2bi_data_from_memory,
    output logic                 l2bi_fill_ack,
    input  logic                 l2bi_stall,
    output l2req_packet_t        l2a_request,
    output cache_line_data_t     l2a_data_from_memory,
    output logic                 l2a_is_l2_fill
);

    localparam int              CNT_W   = $clog2(FILL_BURST_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILL_BURST_LIMIT);

    logic [NUM_CORES-1:0] w_core_req;
    logic                 w_any_core;
    logic [NUM_CORES-1:0] w_grant;
    grant_kind_t          w_kind;
    l2req_packet_t        w_core_pkt;
    l2req_packet_t        w_sel_req;

    logic [CNT_W-1:0]     r_burst_cnt;
    l2req_packet_t        r_l2a_request;
    cache_line_data_t     r_l2a_data;
    logic                 r_l2a_is_fill;

    // Stall gates cores only; fills must always drain the miss queue.
    assign w_core_req = l2i_request_valid & {NUM_CORES{~l2bi_stall}};
    assign w_any_core = |w_core_req;

    always_comb begin
        w_kind = GRANT_IDLE;
        if ((r_burst_cnt == CNT_MAX) && w_any_core) begin
            w_kind = GRANT_CORE;
        end else if (l2bi_fill_valid) begin
            w_kind = GRANT_FILL;
        end else if (w_any_core) begin
            w_kind = GRANT_CORE;
        end
    end

    rr_arbiter #(
        .NUM_REQUESTERS(NUM_CORES)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .i_request   (w_core_req),
        .i_update_lru(reset && (w_kind == GRANT_CORE)),
        .o_grant     (w_grant)
    );

    always_comb begin
        w_core_pkt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant[i]) begin
                w_core_pkt = l2i_request[i];
            end
        end
        w_sel_req = (w_kind == GRANT_FILL) ? l2bi_request : w_core_pkt;
        w_sel_req.valid = 1'b1;
    end

    assign l2_ready      = (reset && (w_kind == GRANT_CORE)) ? w_grant : '0;
    assign l2bi_fill_ack = reset && (w_kind == GRANT_FILL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_burst_cnt   <= '0;
            r_l2a_request <= '0;
            r_l2a_data    <= '0;
            r_l2a_is_fill <= 1'b0;
        end else begin
            case (w_kind)
                GRANT_FILL: begin
                    if (r_burst_cnt != CNT_MAX) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                    r_l2a_request <= w_sel_req;
                    r_l2a_data    <= l2bi_data_from_memory;
                    r_l2a_is_fill <= 1'b1;
                end
                GRANT_CORE: begin
                    r_burst_cnt   <= '0;
                    r_l2a_request <= w_sel_req;
                    r_l2a_data    <= '0;
                    r_l2a_is_fill <= 1'b0;
                end
                default: begin
                    r_burst_cnt   <= '0;
                    r_l2a_request <= '0;
                    r_l2a_data    <= '0;
                    r_l2a_is_fill <= 1'b0;
                end
            endcase
        end
    end

    assign l2a_request          = r_l2a_request;
    assign l2a_data_from_memory = r_l2a_data;
    assign l2a_is_l2_fill       = r_l2a_is_fill;

endmodule

// File: tb/tb_l2_cache_arb_sched.sv
// tb/tb_l2_cache_arb_sched.sv - table-driven scoreboard bench for l2_cache_arb_sched
module tb_l2_cache_arb_sched;
    import l2_cache_arb_sched_pkg::*;

    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC-1:0]    l2i_request_valid;
    l2req_packet_t    l2i_request [NC];
    logic [NC-1:0]    l2_ready;
    logic             l2bi_fill_valid;
    l2req_packet_t    l2bi_request;
    cache_line_data_t l2bi_data_from_memory;
    logic             l2bi_fill_ack;
    logic             l2bi_stall;
    l2req_packet_t    l2a_request;
    cache_line_data_t l2a_data_from_memory;
    logic             l2a_is_l2_fill;

    always #5 clk = ~clk;

    l2_cache_arb_sched #(
        .NUM_CORES(NC),
        .FILL_BURST_LIMIT(8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .l2i_request_valid    (l2i_request_valid),
        .l2i_request          (l2i_request),
        .l2_ready             (l2_ready),
        .l2bi_fill_valid      (l2bi_fill_valid),
        .l2bi_request         (l2bi_request),
        .l2bi_data_from_memory(l2bi_data_from_memory),
        .l2bi_fill_ack        (l2bi_fill_ack),
        .l2bi_stall           (l2bi_stall),
        .l2a_request          (l2a_request),
        .l2a_data_from_memory (l2a_data_from_memory),
        .l2a_is_l2_fill       (l2a_is_l2_fill)
    );

    typedef struct {
        logic          rst;
        logic [NC-1:0] valid;
        logic          stall;
        logic          fill;
        logic [NC-1:0] exp_ready;
        logic          exp_ack;
    } vec_t;

    typedef struct {
        l2req_packet_t    req;
        cache_line_data_t data;
        logic             is_fill;
    } out_t;

    vec_t vecs[$];
    out_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mkv(input logic rst, input logic [NC-1:0] valid, input logic stall,
                                 input logic fill, input logic [NC-1:0] er, input logic ea);
        vec_t v;
        v.rst = rst; v.valid = valid; v.stall = stall; v.fill = fill;
        v.exp_ready = er; v.exp_ack = ea;
        return v;
    endfunction

    function automatic l2req_packet_t core_pkt(input int i);
        l2req_packet_t p;
        p.valid       = 1'b0;
        p.core        = CORE_ID_WIDTH'(i);
        p.packet_type = (i == 1) ? L2REQ_STORE : L2REQ_LOAD;
        p.address     = 32'h1000 + 32'(i) * 32'h40;
        return p;
    endfunction

    task automatic chk(input bit ok, input int idx, input string name, input string act, input string exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL vec%0d %s: got %s expected %s", idx, name, act, exp);
        end
    endtask

    initial begin
        l2req_packet_t fill_pkt;
        cache_line_data_t fill_line;

        fill_pkt.valid       = 1'b0;
        fill_pkt.core        = 4'd2;
        fill_pkt.packet_type = L2REQ_LOAD;
        fill_pkt.address     = 32'h0000_2000;
        fill_line            = {64{8'hA5}};

        reset                 = 1'b0;
        l2i_request_valid     = '0;
        l2bi_fill_valid       = 1'b0;
        l2bi_stall            = 1'b0;
        l2bi_request          = fill_pkt;
        l2bi_data_from_memory = fill_line;
        for (int i = 0; i < NC; i++) l2i_request[i] = core_pkt(i);

        vecs.push_back(mkv(0, 4'b0000, 0, 0, 4'b0000, 0));
        vecs.push_back(mkv(1, 4'b0001, 0, 0, 4'b0001, 0));
        vecs.push_back(mkv(0, 4'b1111, 0, 1, 4'b0000, 0));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mkv(1, 4'b1111, 0, 0, 4'b0001, 0));
            vecs.push_back(mkv(1, 4'b1111, 0, 0, 4'b0010, 0));
            vecs.push_back(mkv(1, 4'b1111, 0, 0, 4'b0100, 0));
            vecs.push_back(mkv(1, 4'b1111, 0, 0, 4'b1000, 0));
        end
        vecs.push_back(mkv(1, 4'b1001, 1, 1, 4'b0000, 1));
        vecs.push_back(mkv(1, 4'b1001, 1, 0, 4'b0000, 0));
        vecs.push_back(mkv(1, 4'b1001, 0, 0, 4'b0001, 0));
        vecs.push_back(mkv(1, 4'b0010, 0, 0, 4'b0010, 0));
        vecs.push_back(mkv(1, 4'b1010, 0, 0, 4'b1000, 0));
        vecs.push_back(mkv(1, 4'b1010, 0, 0, 4'b0010, 0));
        vecs.push_back(mkv(1, 4'b0100, 0, 1, 4'b0000, 1));
        vecs.push_back(mkv(1, 4'b0000, 0, 0, 4'b0000, 0));
        for (int r = 0; r < 8; r++) vecs.push_back(mkv(1, 4'b0010, 0, 1, 4'b0000, 1));
        vecs.push_back(mkv(1, 4'b0010, 0, 1, 4'b0010, 0));
        vecs.push_back(mkv(1, 4'b0010, 0, 1, 4'b0000, 1));
        vecs.push_back(mkv(1, 4'b0000, 0, 0, 4'b0000, 0));
        for (int r = 0; r < 9; r++) vecs.push_back(mkv(1, 4'b0000, 0, 1, 4'b0000, 1));
        vecs.push_back(mkv(1, 4'b0100, 0, 1, 4'b0100, 0));
        vecs.push_back(mkv(1, 4'b0100, 0, 1, 4'b0000, 1));
        vecs.push_back(mkv(0, 4'b1111, 0, 1, 4'b0000, 0));
        vecs.push_back(mkv(1, 4'b1111, 0, 0, 4'b0001, 0));
        vecs.push_back(mkv(1, 4'b1111, 0, 0, 4'b0010, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            out_t e;
            out_t got;
            int   gidx;
            v = vecs[k];
            reset             = v.rst;
            l2i_request_valid = v.valid;
            l2bi_stall        = v.stall;
            l2bi_fill_valid   = v.fill;

            @(negedge clk);
            chk(l2_ready === v.exp_ready, k, "l2_ready",
                $sformatf("%b", l2_ready), $sformatf("%b", v.exp_ready));
            chk(l2bi_fill_ack === v.exp_ack, k, "fill_ack",
                $sformatf("%b", l2bi_fill_ack), $sformatf("%b", v.exp_ack));
            chk($onehot0(l2_ready), k, "ready_onehot0",
                $sformatf("%b", l2_ready), "one-hot or zero");

            e.req = '0; e.data = '0; e.is_fill = 1'b0;
            gidx = -1;
            for (int i = 0; i < NC; i++) if (v.exp_ready[i]) gidx = i;
            if (v.rst && v.exp_ack) begin
                e.req = fill_pkt; e.req.valid = 1'b1; e.data = fill_line; e.is_fill = 1'b1;
            end else if (v.rst && gidx >= 0) begin
                e.req = core_pkt(gidx); e.req.valid = 1'b1;
            end
            sb.push_back(e);

            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk(1'b0, k, "scoreboard_empty", "empty", "entry");
            end else begin
                got = sb.pop_front();
                chk(l2a_request === got.req, k, "l2a_request",
                    $sformatf("%h", l2a_request), $sformatf("%h", got.req));
                chk(l2a_is_l2_fill === got.is_fill, k, "l2a_is_l2_fill",
                    $sformatf("%b", l2a_is_l2_fill), $sformatf("%b", got.is_fill));
                chk(l2a_data_from_memory === got.data, k, "l2a_data",
                    $sformatf("%h", l2a_data_from_memory), $sformatf("%h", got.data));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
